// File: rtl/execute_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO registers.
// One result bit per cycle: 32 ITER cycles, one FIX cycle for sign correction, one DONE pulse.
module execute_muldiv (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_busA,
   input  logic [31:0] i_busB,
   input  logic        i_exception,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_div_by_zero,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] opnd_q, opnd_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        op_is_div;
   logic        op_signed;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [31:0] div_sub;
   logic        div_ge;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   assign op_is_div = (i_op == OpDiv) || (i_op == OpDivu);
   assign op_signed = (i_op == OpMult) || (i_op == OpDiv);
   assign abs_a     = (op_signed && i_busA[31]) ? -i_busA : i_busA;
   assign abs_b     = (op_signed && i_busB[31]) ? -i_busB : i_busB;

   // Multiply: acc_lo holds the remaining multiplier bits and collects product low bits.
   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   // A successful trial subtraction always leaves a result below 2^32, so 32 bits suffice.
   assign div_shift = {acc_hi_q, acc_lo_q[31]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_sub   = div_shift[31:0] - opnd_q;

   assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quot_fix  = neg_q ? -acc_lo_q : acc_lo_q;
   assign rem_fix   = rneg_q ? -acc_hi_q : acc_hi_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      case (state_q)
         StIdle: begin
            if (i_start) begin
               case (i_op)
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     if (op_is_div && (i_busB == 32'd0)) begin
                        state_d = StDone;
                        dz_d    = 1'b1;
                     end else begin
                        state_d  = StIter;
                        cnt_d    = 5'd0;
                        acc_hi_d = 32'd0;
                        acc_lo_d = op_is_div ? abs_a : abs_b;
                        opnd_d   = op_is_div ? abs_b : abs_a;
                        is_div_d = op_is_div;
                        neg_d    = op_signed && (i_busA[31] ^ i_busB[31]);
                        rneg_d   = op_signed && op_is_div && i_busA[31];
                        dz_d     = 1'b0;
                     end
                  end
                  OpMthi:  hi_d = i_busA;
                  OpMtlo:  lo_d = i_busA;
                  default: ;
               endcase
            end
         end
         StIter: begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_q) begin
               acc_hi_d = div_ge ? div_sub : div_shift[31:0];
               acc_lo_d = {acc_lo_q[30:0], div_ge};
            end else begin
               acc_hi_d = mul_sum[32:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
            end
            if (cnt_q == 5'd31) begin
               state_d = StFix;
            end
         end
         StFix: begin
            state_d = StDone;
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
         end
         StDone: begin
            state_d = StIdle;
            dz_d    = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // A flush overrides everything above, including a same-cycle request.
      if (i_exception) begin
         state_d = StIdle;
         cnt_d   = 5'd0;
         dz_d    = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= 5'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opnd_q   <= 32'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign o_busy        = (state_q == StIter) || (state_q == StFix);
   assign o_done        = (state_q == StDone);
   assign o_div_by_zero = (state_q == StDone) && dz_q;
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed vector table, flush/reset sequences and random ops
// checked against a plain-arithmetic model of HI/LO.
module tb_execute_muldiv;

   localparam logic [2:0] OpNone  = 3'b000;
   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] bus_a;
   logic [31:0] bus_b;
   logic        exc;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_hi  = 32'd0;
   logic [31:0] m_lo  = 32'd0;

   always #5 clk = ~clk;

   execute_muldiv dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_op         (op),
      .i_busA       (bus_a),
      .i_busB       (bus_b),
      .i_exception  (exc),
      .o_busy       (busy),
      .o_done       (done),
      .o_div_by_zero(dz),
      .o_hi         (hi),
      .o_lo         (lo)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // {HI, LO} from the arithmetic definition; divisor is never zero here.
   function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] a,
                                         input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint          q;
      longint          r;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      up = 64'(a) * 64'(b);
      model = 64'd0;
      case (mop)
         OpMult:  model = 64'(sa * sb);
         OpMultu: model = up;
         OpDiv: begin
            q = sa / sb;
            r = sa % sb;
            model = {r[31:0], q[31:0]};
         end
         OpDivu:  model = {a % b, a / b};
         default: model = {m_hi, m_lo};
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0:       rnd_val = 32'h0000_0000;
         1:       rnd_val = 32'h0000_0001;
         2:       rnd_val = 32'hFFFF_FFFF;
         3:       rnd_val = 32'h8000_0000;
         4:       rnd_val = 32'h7FFF_FFFF;
         default: rnd_val = $urandom;
      endcase
   endfunction

   // Cycle k is the k-th cycle after the accept edge (k = 0 is the first).
   // Normal ops: busy in cycles 0..32, done in cycle 33. Divide by zero: done in cycle 0.
   task automatic run_muldiv(input string tag, input logic [2:0] mop, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                             input logic edz, input bit poke);
      int   busy_n;
      int   done_at;
      logic dz_seen;
      start = 1'b1;
      op    = mop;
      bus_a = a;
      bus_b = b;
      step();
      start   = 1'b0;
      busy_n  = 0;
      done_at = -1;
      dz_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (poke && k == 5) begin
            start = 1'b1;
            op    = OpMultu;
            bus_a = $urandom;
            bus_b = $urandom;
         end
         if (poke && k == 10) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            done_at = k;
            dz_seen = dz;
            break;
         end
         step();
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, 64'(done_at), edz ? 64'd0 : 64'd33);
      chk({tag, "_busy_cycles"}, 64'(busy_n), edz ? 64'd0 : 64'd33);
      chk({tag, "_dz"}, 64'(dz_seen), 64'(edz));
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      step();
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic run_mt(input string tag, input logic [2:0] mop, input logic [31:0] a);
      start = 1'b1;
      op    = mop;
      bus_a = a;
      step();
      start = 1'b0;
      if (mop == OpMthi) m_hi = a;
      if (mop == OpMtlo) m_lo = a;
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
      chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         if (done || busy) seen++;
         step();
      end
      chk({tag, "_quiet"}, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [63:0] e;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rdz;

      vecs[0] = '{"multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0};
      vecs[1] = '{"mult_m1",   OpMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0};
      vecs[2] = '{"div_m7_2",  OpDiv,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{"divu_100_7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      vecs[4] = '{"div_ovf",   OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
      // Divide by zero leaves HI/LO as the previous row wrote them.
      vecs[5] = '{"divu_5_0",  OpDivu,  32'd5, 32'd0, 32'h0, 32'h8000_0000, 1'b1};

      // Reset takes priority over a simultaneous flush and MTHI request.
      rst_n = 1'b0;
      start = 1'b1;
      op    = OpMthi;
      bus_a = 32'hFFFF_FFFF;
      bus_b = 32'd0;
      exc   = 1'b1;
      step();
      step();
      start = 1'b0;
      exc   = 1'b0;
      rst_n = 1'b1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      step();

      foreach (vecs[i]) begin
         run_muldiv(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                    vecs[i].dz, 1'b0);
      end

      // Flush at iteration 10 of a MULT, then MTLO on the very next cycle.
      run_mt("mthi_pre", OpMthi, 32'hAAAA_0000);
      run_mt("mtlo_pre", OpMtlo, 32'h0000_5555);
      start = 1'b1;
      op    = OpMult;
      bus_a = 32'd3;
      bus_b = 32'd5;
      step();
      start = 1'b0;
      for (int k = 0; k < 10; k++) step();
      exc = 1'b1;
      step();
      exc = 1'b0;
      chk("exc_busy", 64'(busy), 64'd0);
      chk("exc_done", 64'(done), 64'd0);
      chk("exc_hi", 64'(hi), 64'(m_hi));
      chk("exc_lo", 64'(lo), 64'(m_lo));
      run_mt("mtlo_after_exc", OpMtlo, 32'h0000_1234);
      expect_quiet("exc_nodone", 40);

      // Flush in IDLE discards a same-cycle request.
      exc   = 1'b1;
      start = 1'b1;
      op    = OpMthi;
      bus_a = 32'hDEAD_BEEF;
      step();
      op = OpMult;
      step();
      exc   = 1'b0;
      start = 1'b0;
      chk("exc_start_hi", 64'(hi), 64'(m_hi));
      chk("exc_start_busy", 64'(busy), 64'd0);

      // A request arriving mid-ITER must not disturb the running divide.
      run_muldiv("divu_poked", OpDivu, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b1);

      // Reset at iteration 20 of a DIVU.
      start = 1'b1;
      op    = OpDivu;
      bus_a = 32'd999;
      bus_b = 32'd10;
      step();
      start = 1'b0;
      for (int k = 0; k < 20; k++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_dz", 64'(dz), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      expect_quiet("midrst_nodone", 40);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = rnd_val();
         rb  = rnd_val();
         if (rop == OpMthi || rop == OpMtlo) begin
            run_mt($sformatf("rnd%0d_mt", n), rop, ra);
         end else if (rop >= OpMult && rop <= OpDivu) begin
            rdz = (rop == OpDiv || rop == OpDivu) && (rb == 32'd0);
            e   = rdz ? {m_hi, m_lo} : model(rop, ra, rb);
            run_muldiv($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, e[63:32], e[31:0],
                       rdz, 1'b0);
         end else begin
            run_mt($sformatf("rnd%0d_none", n), rop, ra);
         end
      end
      op = OpNone;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: i_clk and i_rst_n, sampled only on the rising edge of i_clk.
REQ-002 i_clk  in  1  rising-edge clock.
REQ-003 i_rst_n  in  1  synchronous active-low reset.
REQ-004 i_start  in  1  operation request, qualified with i_op.
REQ-005 i_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-006 i_busA  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 i_busB  in  32  operand B: multiplier or divisor.
REQ-008 i_exception  in  1  pipeline flush; aborts any operation in flight.
REQ-009 o_busy  out  1  stall request to the decode/execute boundary.
REQ-010 o_done  out  1  one-cycle pulse marking MULT/DIV completion.
REQ-011 o_div_by_zero  out  1  qualified by o_done; the completed divide had i_busB==0.
REQ-012 o_hi, o_lo  out  32 each  architectural HI/LO registers.

Function
REQ-013 States SHALL be IDLE, ITER, FIX and DONE.
REQ-014 In IDLE, i_start with op MULT/MULTU/DIV/DIVU and i_exception=0 SHALL latch the operands and enter ITER with the iteration counter at 0.
REQ-015 In IDLE, i_start with op MTHI or MTLO SHALL write i_busA to o_hi or o_lo at the next edge, stay in IDLE and leave o_busy low.
REQ-016 Signed ops (MULT, DIV) SHALL use the operand magnitudes internally and record the result signs at accept.
REQ-017 ITER SHALL run exactly 32 cycles: shift-add for multiply, restoring divide at one quotient bit per cycle; the counter SHALL wrap 31->0 on the transition to FIX.
REQ-018 FIX SHALL take one cycle to apply sign correction and write HI/LO at the end of that cycle.
REQ-019 Sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
REQ-020 Multiply results: HI = product[63:32], LO = product[31:0].
REQ-021 Divide results: LO = quotient, HI = remainder.
REQ-022 Arithmetic SHALL be modulo 2^32 per register: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-023 o_busy SHALL be 1 in ITER and FIX, i.e. for the 33 cycles after the accept edge, and 0 in IDLE and DONE.
REQ-024 DONE SHALL last one cycle with o_done=1, then go to IDLE; the accept-edge to o_done latency is 34 cycles.
REQ-025 DIV/DIVU with i_busB==0 SHALL skip ITER and FIX: go straight to DONE with o_div_by_zero=1, o_busy never set, HI/LO unchanged.
REQ-026 i_start SHALL be ignored in ITER and FIX; in DONE it SHALL be ignored, and upstream holds it until IDLE.
REQ-027 i_exception=1 in any state SHALL force IDLE at the next edge with o_busy=0, o_done=0, o_div_by_zero=0 and HI/LO unchanged; a same-cycle i_start SHALL be discarded.
REQ-028 HI/LO SHALL change only at the FIX write edge, on MTHI/MTLO, or on reset.

Reset
REQ-029 i_rst_n=0 at a clock edge SHALL set state IDLE, counter 0, o_busy=0, o_done=0, o_div_by_zero=0, o_hi=0, o_lo=0 and clear all internal operand/accumulator registers, regardless of state (including mid-ITER).
REQ-030 Reset SHALL take priority over i_exception and i_start.
REQ-031 Outputs SHALL NOT change between edges in response to i_rst_n.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_busy high for 33 cycles, o_done at accept+34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT 0xFFFFFFFF x 0xFFFFFFFF -> HI=0x00000000, LO=0x00000001; DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> o_done and o_div_by_zero high the cycle after accept, o_busy never high, HI/LO unchanged.
REQ-035 MULT accepted, i_exception pulsed at iteration 10 -> o_busy low next cycle, no o_done, HI/LO keep their prior values; a new MTLO 0x1234 the cycle after -> LO=0x1234.
REQ-036 i_rst_n low at iteration 20 of a DIVU -> the next edge gives all outputs 0 and state IDLE; a new i_start during ITER is ignored (results match the first operation only).
